pit_timer_ctrl: RTL and testbench

PIT_TIMER_CTRL -- requirements
Module: pit_timer_ctrl

---
 rtl/pit_timer_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pit_timer_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pit_timer_ctrl.sv
// pit_timer_ctrl: single-channel interval timer (rate generator / square wave)
// with byte-wide bus access, count latch and a pulse on each output rising edge.
module pit_timer_ctrl #(
    parameter int unsigned DIV = 50
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       wr_stb,
    input  logic       rd_stb,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       gate,
    output logic       pit_out,
    output logic       irq_pulse
);
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {WAIT_COUNT, LOAD, COUNT} state_t;
    typedef enum logic {MODE2, MODE3} mode_t;

    state_t        state;
    mode_t         mode;
    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    access;
    logic          wr_ptr, rd_ptr;
    logic [7:0]    lsb_stage;
    logic [15:0]   n_reg, counter, latch;
    logic          latch_valid;
    logic          gate_d, pit_d;

    logic          ctrl_wr, latch_cmd, mode_wr, cnt_wr, cnt_done, rd_en;
    logic          gate_rise, gate_fall, rd_msb, rd_last;
    logic [15:0]   new_cnt, n_hi, n_lo, rd_src;

    assign tick      = (presc == PW'(DIV - 1));
    assign ctrl_wr   = wr_stb & a0 & (din[7:6] == 2'b00);
    assign latch_cmd = ctrl_wr & (din[5:4] == 2'b00);
    assign mode_wr   = ctrl_wr & (din[5:4] != 2'b00);
    assign cnt_wr    = wr_stb & ~a0;
    assign cnt_done  = cnt_wr & ((access != 2'b11) | wr_ptr);
    assign rd_en     = rd_stb & ~wr_stb & ~a0;
    assign gate_rise = gate & ~gate_d;
    assign gate_fall = ~gate & gate_d;
    // Square wave: odd counts run one extra tick high and one fewer low.
    assign n_hi      = n_reg[0] ? n_reg + 16'd1 : n_reg;
    assign n_lo      = n_reg[0] ? n_reg - 16'd1 : n_reg;
    assign rd_src    = latch_valid ? latch : counter;
    assign rd_msb    = (access == 2'b10) | ((access == 2'b11) & rd_ptr);
    assign rd_last   = (access != 2'b11) | rd_ptr;

    always_comb begin
        new_cnt = {din, lsb_stage};
        case (access)
            2'b01:   new_cnt = {8'h00, din};
            2'b10:   new_cnt = {din, 8'h00};
            default: ;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_COUNT;
            mode        <= MODE2;
            access      <= 2'b11;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            lsb_stage   <= '0;
            n_reg       <= '0;
            counter     <= '0;
            latch       <= '0;
            latch_valid <= 1'b0;
            gate_d      <= 1'b0;
            pit_d       <= 1'b1;
            pit_out     <= 1'b1;
            irq_pulse   <= 1'b0;
            dout        <= '0;
        end else begin
            gate_d    <= gate;
            pit_d     <= pit_out;
            irq_pulse <= pit_out & ~pit_d;

            if (latch_cmd && !latch_valid) begin
                latch       <= counter;
                latch_valid <= 1'b1;
            end

            if (rd_en) begin
                dout <= rd_msb ? rd_src[15:8] : rd_src[7:0];
                if (access == 2'b11)
                    rd_ptr <= ~rd_ptr;
                if (rd_last)
                    latch_valid <= 1'b0;
            end

            // The reload register only changes once the full count is in,
            // so a running period never sees a half-written value.
            if (cnt_wr) begin
                if (access == 2'b11 && !wr_ptr) begin
                    lsb_stage <= din;
                    wr_ptr    <= 1'b1;
                end else begin
                    n_reg  <= new_cnt;
                    wr_ptr <= 1'b0;
                end
            end

            if (mode_wr) begin
                access  <= din[5:4];
                mode    <= (din[2:1] == 2'b11) ? MODE3 : MODE2;
                pit_out <= 1'b1;
                wr_ptr  <= 1'b0;
                rd_ptr  <= 1'b0;
                state   <= WAIT_COUNT;
            end else begin
                if (gate_fall)
                    pit_out <= 1'b1;
                case (state)
                    WAIT_COUNT: if (cnt_done) state <= LOAD;
                    LOAD: begin
                        if (tick && gate) begin
                            counter <= (mode == MODE3) ? n_hi : n_reg;
                            pit_out <= 1'b1;
                            state   <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (gate_rise) begin
                            state <= LOAD;
                        end else if (tick && gate) begin
                            if (mode == MODE2) begin
                                if (counter == 16'd1) begin
                                    counter <= n_reg;
                                    pit_out <= 1'b1;
                                end else begin
                                    counter <= counter - 16'd1;
                                    if (counter == 16'd2)
                                        pit_out <= 1'b0;
                                end
                            end else begin
                                if (counter == 16'd2) begin
                                    pit_out <= ~pit_out;
                                    counter <= pit_out ? n_lo : n_hi;
                                end else begin
                                    counter <= counter - 16'd2;
                                end
                            end
                        end
                    end
                    default: state <= WAIT_COUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pit_timer_ctrl.sv
// Bench for pit_timer_ctrl: predicts pit_out/irq_pulse/dout from the tick
// schedule of each programmed count and compares every cycle.
module tb_pit_timer_ctrl;
    localparam int DIV = 50;

    logic       clk_50m = 1'b0;
    logic       rst_n, wr_stb, rd_stb, a0, gate;
    logic [7:0] din, dout;
    logic       pit_out, irq_pulse;

    pit_timer_ctrl #(.DIV(DIV)) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .wr_stb   (wr_stb),
        .rd_stb   (rd_stb),
        .a0       (a0),
        .din      (din),
        .dout     (dout),
        .gate     (gate),
        .pit_out  (pit_out),
        .irq_pulse(irq_pulse)
    );

    always #10 clk_50m = ~clk_50m;

    // Clock edges since reset release; ticks fall on edges that are multiples of DIV.
    int cyc;
    always @(posedge clk_50m or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    int         n_tests = 0, n_fail = 0;
    bit         m3, waiting, gated, pend, wptr, rptr, lvalid;
    int         n, t0, pend_n, pend_t0;
    logic [1:0] acc;
    logic [7:0] lsb, last_dout;
    logic [15:0] lval;
    bit         e1, e2;

    function automatic bit model_pit(int c);
        int k, p;
        if (waiting || gated || c < t0) return 1'b1;
        k = (c - t0) / DIV;
        p = k % n;
        if (!m3) return (p != n - 1);
        return (p < (n + 1) / 2);
    endfunction

    // Count value seen by the bus at edge e, for a running rate generator.
    function automatic logic [15:0] model_count(int e);
        int k;
        k = (e - 1 - t0) / DIV;
        return 16'(n - (k % n));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        bit e;
        @(negedge clk_50m);
        if (pend && cyc >= pend_t0) begin
            n = pend_n;
            t0 = pend_t0;
            pend = 1'b0;
        end
        e = model_pit(cyc);
        chk("pit_out", {15'd0, pit_out}, {15'd0, e});
        chk("irq_pulse", {15'd0, irq_pulse}, {15'd0, e1 & ~e2});
        e2 = e1;
        e1 = e;
    endtask

    task automatic run(input int nc);
        repeat (nc) step();
    endtask

    task automatic ctrl(input logic [7:0] d, input bit with_rd);
        if (d[7:6] == 2'b00) begin
            if (d[5:4] == 2'b00) begin
                if (!lvalid) begin
                    lval = model_count(cyc + 1);
                    lvalid = 1'b1;
                end
            end else begin
                acc = d[5:4];
                m3 = (d[2:1] == 2'b11);
                waiting = 1'b1;
                pend = 1'b0;
                wptr = 1'b0;
                rptr = 1'b0;
            end
        end
        wr_stb = 1'b1; a0 = 1'b1; din = d; rd_stb = with_rd;
        step();
        wr_stb = 1'b0; rd_stb = 1'b0;
    endtask

    task automatic cnt(input logic [7:0] d);
        int w, newn, m;
        w = cyc + 1;
        if (acc == 2'd3 && !wptr) begin
            lsb = d;
            wptr = 1'b1;
        end else begin
            case (acc)
                2'd1:    newn = int'(d);
                2'd2:    newn = int'(d) * 256;
                default: newn = int'(d) * 256 + int'(lsb);
            endcase
            wptr = 1'b0;
            if (waiting) begin
                waiting = 1'b0;
                n = newn;
                t0 = (w / DIV + 1) * DIV;
            end else begin
                m = (w - t0) / (n * DIV) + 1;
                pend_t0 = t0 + m * n * DIV;
                pend_n = newn;
                pend = 1'b1;
            end
        end
        wr_stb = 1'b1; a0 = 1'b0; din = d;
        step();
        wr_stb = 1'b0;
    endtask

    task automatic rd();
        logic [15:0] src;
        logic [7:0]  ex;
        bit          msb, fin;
        src = lvalid ? lval : model_count(cyc + 1);
        msb = (acc == 2'd2) || (acc == 2'd3 && rptr);
        fin = (acc != 2'd3) || rptr;
        ex = msb ? src[15:8] : src[7:0];
        if (acc == 2'd3) rptr = ~rptr;
        if (fin) lvalid = 1'b0;
        rd_stb = 1'b1; a0 = 1'b0;
        step();
        rd_stb = 1'b0;
        chk("dout", {8'd0, dout}, {8'd0, ex});
        last_dout = ex;
    endtask

    task automatic model_reset();
        waiting = 1'b1; gated = 1'b0; pend = 1'b0; m3 = 1'b0; acc = 2'd3;
        wptr = 1'b0; rptr = 1'b0; lvalid = 1'b0; e1 = 1'b1; e2 = 1'b1;
        n = 2; t0 = 0; last_dout = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, tests %0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        int nr, nn;
        logic [2:0] d31;
        rst_n = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0; a0 = 1'b0; din = '0; gate = 1'b1;
        model_reset();
        #35;
        chk("rst_pit_out", {15'd0, pit_out}, 16'd1);
        chk("rst_irq", {15'd0, irq_pulse}, 16'd0);
        chk("rst_dout", {8'd0, dout}, 16'd0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        run(5);

        // Rate generator, count 5
        ctrl(8'h34, 1'b0); run(3); cnt(8'h05); cnt(8'h00); run(650);

        // Rate generator 10, writes to other counters ignored, then new count 3
        ctrl(8'h34, 1'b0); run(3); cnt(8'd10); cnt(8'h00); run(320);
        ctrl(8'h74, 1'b0); run(40); ctrl(8'hB6, 1'b0); run(300);
        cnt(8'd3); cnt(8'h00); run(700);

        // Square wave, odd count 5
        ctrl(8'h36, 1'b0); run(3); cnt(8'd5); cnt(8'h00); run(600);

        // Square wave 4 with gate pulled low in the low phase
        ctrl(8'h36, 1'b0); run(3); cnt(8'd4); cnt(8'h00);
        while (cyc < t0 + 2 * DIV + 20) step();
        gated = 1'b1; gate = 1'b0; run(300);
        pend = 1'b0; gated = 1'b0; t0 = ((cyc + 1) / DIV + 1) * DIV; gate = 1'b1;
        run(500);

        // Count latch and read-back, count 0x1234
        ctrl(8'h34, 1'b0); run(3); cnt(8'h34); cnt(8'h12); run(200);
        ctrl(8'h00, 1'b0); run(60); rd(); run(80); rd();
        ctrl(8'h00, 1'b0); run(70); ctrl(8'h00, 1'b0); run(5); rd(); run(55); rd();
        run(10); rd(); run(3); rd();
        ctrl(8'h00, 1'b1);
        chk("wr_rd_same_cycle", {8'd0, dout}, {8'd0, last_dout});
        run(60); rd(); rd();

        // Single-byte access modes and fallback mode decode
        ctrl(8'h14, 1'b0); run(3); cnt(8'd6); run(400); rd(); run(20); rd();
        ctrl(8'h24, 1'b0); run(3); cnt(8'h01); run(120); rd(); run(60); rd();
        ctrl(8'h30, 1'b0); run(3); cnt(8'd4); cnt(8'h00); run(450);

        // Randomised counts and mode encodings
        repeat (6) begin
            nr = $urandom_range(2, 7);
            d31 = 3'($urandom_range(0, 7));
            ctrl({4'b0011, d31, 1'b0}, 1'b0); run(3);
            cnt(8'(nr)); cnt(8'h00);
            run(nr * DIV * 2 + $urandom_range(0, 100));
            if (!m3 && $urandom_range(0, 1) == 1) begin
                nn = $urandom_range(2, 7);
                cnt(8'(nn)); cnt(8'h00);
                run((nn + nr) * DIV * 2);
            end
        end

        // Reset mid-count
        ctrl(8'h34, 1'b0); run(3); cnt(8'd5); cnt(8'h00); run(420);
        #5 rst_n = 1'b0;
        #1;
        chk("midrst_pit_out", {15'd0, pit_out}, 16'd1);
        chk("midrst_dout", {8'd0, dout}, 16'd0);
        chk("midrst_irq", {15'd0, irq_pulse}, 16'd0);
        model_reset();
        @(negedge clk_50m);
        rst_n = 1'b1;
        run(400);
        ctrl(8'h34, 1'b0); run(3); cnt(8'd5); cnt(8'h00); run(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
